riscv_dmi_arbiter: RTL and testbench

- Shares one Debug Module DMI request/response channel between NUM_REQ requesters, e.g. the JTAG DTM and a secondary system-side debug port.
- Round-robin grant; one transaction in flight at a time; the grant is held until the response has been returned to the winner.
- A response timeout converts a hung DM access into a FAILED response, so no requester deadlocks.
- Sits between the DTM/requesters and the DM, in the DM clock domain (clk_i).

---
 rtl/riscv_dmi_arbiter.sv | 179 +++++++++++++++++
 tb/tb_riscv_dmi_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmi_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : riscv_dmi_arbiter
//  Purpose  : Round-robin sharing of one Debug Module DMI channel between
//             NUM_REQ requesters, one transaction in flight, with a DM
//             response timeout that converts a hung access into FAILED.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_dmi_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int OP_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
  input  logic [NUM_REQ*OP_WIDTH-1:0]      req_op_i,
  output logic [NUM_REQ-1:0]               resp_valid_o,
  input  logic [NUM_REQ-1:0]               resp_ready_i,
  output logic [DATA_WIDTH-1:0]            resp_data_o,
  output logic [OP_WIDTH-1:0]              resp_op_o,
  output logic                             dm_req_valid_o,
  input  logic                             dm_req_ready_i,
  output logic [ADDR_WIDTH-1:0]            dm_req_addr_o,
  output logic [DATA_WIDTH-1:0]            dm_req_data_o,
  output logic [OP_WIDTH-1:0]              dm_req_op_o,
  input  logic                             dm_resp_valid_i,
  output logic                             dm_resp_ready_o,
  input  logic [DATA_WIDTH-1:0]            dm_resp_data_i,
  input  logic [OP_WIDTH-1:0]              dm_resp_op_i,
  output logic                             busy_o,
  output logic [7:0]                       timeout_cnt_o
);

  localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [TW-1:0]       TO_LAST   = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
  localparam logic [OP_WIDTH-1:0] OP_FAILED = OP_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DM_REQ  = 2'd1,
    DM_RESP = 2'd2,
    RET     = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [GW-1:0]         rr_ptr;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         winner;
  logic [GW-1:0]         cand;
  logic                  win_found;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [OP_WIDTH-1:0]   rop_q;
  logic [TW-1:0]         timer;
  logic [7:0]            timeout_cnt;
  logic                  timeout_hit;

  // A disabled timeout (TIMEOUT_CYCLES == 0) never fires, however far the timer wraps
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TO_LAST);

  assign dm_req_addr_o = addr_q;
  assign dm_req_data_o = data_q;
  assign dm_req_op_o   = op_q;
  assign resp_data_o   = rdata_q;
  assign resp_op_o     = rop_q;
  assign timeout_cnt_o = timeout_cnt;
  assign busy_o        = (state != IDLE);

  // Round-robin search: first valid requester at or above rr_ptr, wrapping
  always_comb begin
    winner    = '0;
    cand      = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = GW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and handshake outputs; the ready grant is masked while in reset
  always_comb begin
    state_nxt       = state;
    req_ready_o     = '0;
    resp_valid_o    = '0;
    dm_req_valid_o  = 1'b0;
    dm_resp_ready_o = 1'b0;
    case (state)
      IDLE: begin
        dm_resp_ready_o = 1'b1;
        if (win_found && rstn_i) begin
          req_ready_o[winner] = 1'b1;
          state_nxt           = DM_REQ;
        end
      end
      DM_REQ: begin
        dm_req_valid_o = 1'b1;
        if (dm_req_ready_i) state_nxt = DM_RESP;
      end
      DM_RESP: begin
        dm_resp_ready_o = 1'b1;
        if (dm_resp_valid_i || timeout_hit) state_nxt = RET;
      end
      RET: begin
        resp_valid_o[grant] = 1'b1;
        if (resp_ready_i[grant]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: request latch, timer, response latch, timeout counter, rr pointer
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr      <= '0;
      grant       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      op_q        <= '0;
      rdata_q     <= '0;
      rop_q       <= '0;
      timer       <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant  <= winner;
            addr_q <= req_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
            data_q <= req_data_i[winner*DATA_WIDTH +: DATA_WIDTH];
            op_q   <= req_op_i[winner*OP_WIDTH +: OP_WIDTH];
          end
        end
        DM_REQ: begin
          if (dm_req_ready_i) timer <= '0;
        end
        DM_RESP: begin
          timer <= timer + 1'b1;
          // A real response beats a timeout landing in the same cycle
          if (dm_resp_valid_i) begin
            rdata_q <= dm_resp_data_i;
            rop_q   <= dm_resp_op_i;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            rop_q   <= OP_FAILED;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
          end
        end
        RET: begin
          if (resp_ready_i[grant]) begin
            rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmi_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_dmi_arbiter
//  Purpose  : Scoreboard bench for riscv_dmi_arbiter (NUM_REQ=2, timeout 8)
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_dmi_arbiter;

  typedef struct packed {
    logic        idx;
    logic [31:0] data;
    logic [1:0]  op;
  } resp_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
  } dmreq_t;

  logic        clk_i;
  logic        rstn_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [13:0] req_addr_i;
  logic [63:0] req_data_i;
  logic [3:0]  req_op_i;
  logic [1:0]  resp_valid_o;
  logic [1:0]  resp_ready_i;
  logic [31:0] resp_data_o;
  logic [1:0]  resp_op_o;
  logic        dm_req_valid_o;
  logic        dm_req_ready_i;
  logic [6:0]  dm_req_addr_o;
  logic [31:0] dm_req_data_o;
  logic [1:0]  dm_req_op_o;
  logic        dm_resp_valid_i;
  logic        dm_resp_ready_o;
  logic [31:0] dm_resp_data_i;
  logic [1:0]  dm_resp_op_i;
  logic        busy_o;
  logic [7:0]  timeout_cnt_o;

  int tests = 0;
  int fails = 0;

  resp_t  exp_resp[$];
  dmreq_t exp_dm[$];
  int     exp_grant[$];

  int         dm_acc_delay  = 0;
  int         dm_resp_delay = 0;
  bit         dm_respond    = 1'b1;
  logic [1:0] dm_rop        = 2'd0;

  riscv_dmi_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(7), .DATA_WIDTH(32), .OP_WIDTH(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_op_i(req_op_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_op_o(resp_op_o),
    .dm_req_valid_o(dm_req_valid_o), .dm_req_ready_i(dm_req_ready_i),
    .dm_req_addr_o(dm_req_addr_o), .dm_req_data_o(dm_req_data_o), .dm_req_op_o(dm_req_op_o),
    .dm_resp_valid_i(dm_resp_valid_i), .dm_resp_ready_o(dm_resp_ready_o),
    .dm_resp_data_i(dm_resp_data_i), .dm_resp_op_i(dm_resp_op_i),
    .busy_o(busy_o), .timeout_cnt_o(timeout_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_txn(input bit i, input logic [6:0] a, input logic [31:0] d,
                          input logic [1:0] o, input logic [31:0] rd, input logic [1:0] ro);
    exp_grant.push_back(int'(i));
    exp_dm.push_back({a, d, o});
    exp_resp.push_back({i, rd, ro});
  endtask

  task automatic set_req(input bit i, input logic [6:0] a, input logic [31:0] d, input logic [1:0] o);
    req_addr_i[i*7 +: 7]  = a;
    req_data_i[i*32 +: 32] = d;
    req_op_i[i*2 +: 2]    = o;
    req_valid_i[i]        = 1'b1;
  endtask

  // Raise one request, wait for its grant, drop it right after the accepting edge
  task automatic issue(input bit i, input logic [6:0] a, input logic [31:0] d, input logic [1:0] o);
    int n;
    n = 0;
    set_req(i, a, d, o);
    @(negedge clk_i);
    while (!req_ready_o[i] && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o[i]) chk("grant_timeout", 64'(0), 64'(1));
    @(posedge clk_i);
    #1;
    req_valid_i[i] = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_resp.size() != 0 || busy_o) && n < 300) begin
      tick();
      n++;
    end
    chk("done_timeout", 64'(exp_resp.size() == 0 && !busy_o), 64'(1));
  endtask

  // Response monitor: compares each requester-side response handshake against the scoreboard
  initial begin
    resp_t e;
    forever begin
      @(negedge clk_i);
      if (rstn_i && resp_valid_o != 2'b00) begin
        if (exp_resp.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid_o), 64'(0));
        end else if ((resp_valid_o & resp_ready_i) != 2'b00) begin
          e = exp_resp.pop_front();
          chk("resp_valid", 64'(resp_valid_o), 64'(2'b01 << e.idx));
          chk("resp_data", 64'(resp_data_o), 64'(e.data));
          chk("resp_op", 64'(resp_op_o), 64'(e.op));
        end
      end
    end
  end

  // Grant monitor: one-hot ready and round-robin order
  initial begin
    logic [1:0] g;
    forever begin
      @(negedge clk_i);
      g = req_valid_i & req_ready_o;
      if (req_ready_o != 2'b00) chk("ready_onehot", 64'($countones(req_ready_o) <= 1), 64'(1));
      if (g != 2'b00) begin
        if (exp_grant.size() == 0) chk("grant_unexpected", 64'(g), 64'(0));
        else chk("grant_order", 64'(g), 64'(2'b01 << exp_grant.pop_front()));
      end
    end
  end

  // DM model: checks forwarded fields, applies accept delay, returns a response
  initial begin
    dmreq_t e;
    dmreq_t cap;
    bit     take;
    dm_req_ready_i  = 1'b0;
    dm_resp_valid_i = 1'b0;
    dm_resp_data_i  = '0;
    dm_resp_op_i    = '0;
    forever begin
      @(negedge clk_i);
      if (rstn_i && dm_req_valid_o) begin
        cap = {dm_req_addr_o, dm_req_data_o, dm_req_op_o};
        if (exp_dm.size() == 0) begin
          chk("dm_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_dm.pop_front();
          chk("dm_addr", 64'(cap.addr), 64'(e.addr));
          chk("dm_data", 64'(cap.data), 64'(e.data));
          chk("dm_op", 64'(cap.op), 64'(e.op));
        end
        for (int k = 0; k < dm_acc_delay; k++) begin
          @(posedge clk_i);
          @(negedge clk_i);
          chk("dm_req_stable", 64'({dm_req_valid_o, dm_req_addr_o, dm_req_data_o, dm_req_op_o}),
              64'({1'b1, cap}));
        end
        dm_req_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        dm_req_ready_i = 1'b0;
        if (dm_respond) begin
          repeat (dm_resp_delay) @(posedge clk_i);
          #1;
          dm_resp_valid_i = 1'b1;
          dm_resp_data_i  = (cap.addr == 7'h11) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(cap.addr));
          dm_resp_op_i    = dm_rop;
          @(negedge clk_i);
          take = busy_o && dm_resp_ready_o;
          @(posedge clk_i);
          #1;
          dm_resp_valid_i = 1'b0;
          chk("resp_latency", 64'(resp_valid_o != 2'b00), 64'(take));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         gcount;
    logic [1:0] g;
    rstn_i       = 1'b0;
    req_valid_i  = '0;
    req_addr_i   = '0;
    req_data_i   = '0;
    req_op_i     = '0;
    resp_ready_i = 2'b11;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_req_ready", 64'(req_ready_o), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid_o), 64'(0));
    chk("rst_dm_req_valid", 64'(dm_req_valid_o), 64'(0));
    chk("rst_dm_resp_ready", 64'(dm_resp_ready_o), 64'(1));
    chk("rst_timeout_cnt", 64'(timeout_cnt_o), 64'(0));
    rstn_i = 1'b1;
    tick();

    // Single requester read, DM answers two cycles after accepting
    dm_resp_delay = 1;
    push_txn(1'b0, 7'h11, 32'h0, 2'd1, 32'hDEADBEEF, 2'd0);
    issue(1'b0, 7'h11, 32'h0, 2'd1);
    chk("dm_req_latency", 64'(dm_req_valid_o), 64'(1));
    wait_done();
    dm_resp_delay = 0;

    // rr_ptr now 1: lone req1 moves it back to 0
    push_txn(1'b1, 7'h22, 32'h0, 2'd1, 32'hC0DE0022, 2'd0);
    issue(1'b1, 7'h22, 32'h0, 2'd1);
    wait_done();

    // Contention: both held valid for four grants, expect 0,1,0,1
    push_txn(1'b0, 7'h20, 32'h0, 2'd1, 32'hC0DE0020, 2'd0);
    push_txn(1'b1, 7'h31, 32'h12345678, 2'd2, 32'hC0DE0031, 2'd0);
    push_txn(1'b0, 7'h20, 32'h0, 2'd1, 32'hC0DE0020, 2'd0);
    push_txn(1'b1, 7'h31, 32'h12345678, 2'd2, 32'hC0DE0031, 2'd0);
    set_req(1'b0, 7'h20, 32'h0, 2'd1);
    set_req(1'b1, 7'h31, 32'h12345678, 2'd2);
    gcount = 0;
    n = 0;
    while (gcount < 4 && n < 400) begin
      @(negedge clk_i);
      g = req_valid_i & req_ready_o;
      if (g != 2'b00) gcount++;
      n++;
    end
    chk("contention_grants", 64'(gcount), 64'(4));
    @(posedge clk_i);
    #1;
    req_valid_i = 2'b00;
    wait_done();

    // Backpressure on both DM request and requester response
    dm_acc_delay = 5;
    resp_ready_i = 2'b00;
    push_txn(1'b0, 7'h05, 32'hCAFEF00D, 2'd2, 32'hC0DE0005, 2'd0);
    push_txn(1'b1, 7'h33, 32'h0, 2'd1, 32'hC0DE0033, 2'd0);
    issue(1'b0, 7'h05, 32'hCAFEF00D, 2'd2);
    set_req(1'b1, 7'h33, 32'h0, 2'd1);
    n = 0;
    while (resp_valid_o == 2'b00 && n < 100) begin
      tick();
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      chk("bp_resp_valid", 64'(resp_valid_o), 64'(2'b01));
      chk("bp_resp_data", 64'(resp_data_o), 64'(32'hC0DE0005));
      chk("bp_no_grant", 64'(req_ready_o), 64'(0));
      tick();
    end
    resp_ready_i = 2'b11;
    dm_acc_delay = 0;
    n = 0;
    @(negedge clk_i);
    while (!req_ready_o[1] && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("bp_next_grant", 64'(req_ready_o[1]), 64'(1));
    @(posedge clk_i);
    #1;
    req_valid_i = 2'b00;
    wait_done();

    // Timeout: DM accepts, answers only after 12 cycles (stale by then)
    dm_resp_delay = 12;
    exp_grant.push_back(0);
    exp_dm.push_back({7'h15, 32'h0, 2'd1});
    exp_resp.push_back({1'b0, 32'h0, 2'd2});
    issue(1'b0, 7'h15, 32'h0, 2'd1);
    repeat (8) tick();
    chk("to_not_early", 64'(resp_valid_o), 64'(0));
    tick();
    chk("to_resp_valid", 64'(resp_valid_o), 64'(2'b01));
    chk("to_resp_op", 64'(resp_op_o), 64'(2));
    chk("to_resp_data", 64'(resp_data_o), 64'(0));
    tick();
    chk("to_count", 64'(timeout_cnt_o), 64'(1));
    repeat (8) tick();
    chk("stale_idle", 64'(busy_o), 64'(0));
    dm_resp_delay = 0;

    // Reset in the middle of DM_RESP
    dm_respond = 1'b0;
    exp_grant.push_back(0);
    exp_dm.push_back({7'h0A, 32'h55AA55AA, 2'd2});
    issue(1'b0, 7'h0A, 32'h55AA55AA, 2'd2);
    tick();
    tick();
    @(negedge clk_i);
    rstn_i = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    chk("mid_rst_dm_req_valid", 64'(dm_req_valid_o), 64'(0));
    chk("mid_rst_resp_valid", 64'(resp_valid_o), 64'(0));
    chk("mid_rst_count", 64'(timeout_cnt_o), 64'(0));
    chk("mid_rst_resp_data", 64'(resp_data_o), 64'(0));
    chk("mid_rst_dm_addr", 64'(dm_req_addr_o), 64'(0));
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    dm_respond = 1'b1;
    tick();
    chk("post_rst_busy", 64'(busy_o), 64'(0));
    push_txn(1'b0, 7'h0B, 32'h0BADCAFE, 2'd2, 32'hC0DE000B, 2'd0);
    issue(1'b0, 7'h0B, 32'h0BADCAFE, 2'd2);
    wait_done();

    // Nop from req1 is forwarded; DM status (busy) returned unchanged
    dm_rop = 2'd3;
    push_txn(1'b1, 7'h10, 32'h0, 2'd0, 32'hC0DE0010, 2'd3);
    issue(1'b1, 7'h10, 32'h0, 2'd0);
    wait_done();
    dm_rop = 2'd0;

    repeat (3) tick();
    chk("queues_empty", 64'(exp_grant.size() + exp_dm.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
